param_shift_reg_en: RTL and testbench
=====================================

Name: param_shift_reg_en

Overview:
- Parametrised WIDTH-bit register with clock enable and an operation select.
- Successor to the single-bit enable D flip-flop: adds parallel load, logical/arithmetic shifts, rotates, clear, serial in/out and a zero flag.
- Used as the general-purpose state/data register in datapath exercises (shifters, accumulators, serial converters).

Parameters:
- WIDTH, 8, register width in bits; legal range WIDTH >= 2.
- RESET_VALUE, 0, value loaded into q on reset; WIDTH bits wide.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- en  input  1  clock enable; 0 = hold everything except reset.
- op  input  3  operation select, sampled on the clk edge when en=1.
- d  input  WIDTH  parallel load data.
- si  input  1  serial input bit for SHL/SHR.
- q  output  WIDTH  registered contents.
- so  output  1  registered serial-out: the last bit shifted or rotated out.
- zero  output  1  combinational; 1 when q == 0.

Behaviour:
- One clock, clk. Reset is synchronous and active-high: reset=1 at a rising edge forces q=RESET_VALUE and so=0, independent of en/op/d/si.
- zero follows q combinationally: 1 after reset when RESET_VALUE=0.
- Priority at each rising edge: reset > en=0 (hold q and so) > op decode.
- Op decode when en=1, with q' = next q:
  - 000 HOLD: q'=q.
  - 001 LOAD: q'=d.
  - 010 SHL: q'={q[W-2:0],si}; so'=q[W-1].
  - 011 SHR: q'={si,q[W-1:1]}; so'=q[0].
  - 100 ROL: q'={q[W-2:0],q[W-1]}; so'=q[W-1].
  - 101 ROR: q'={q[0],q[W-1:1]}; so'=q[0].
  - 110 ASR: q'={q[W-1],q[W-1:1]}; so'=q[0]; si ignored.
  - 111 CLR: q'=0 (not RESET_VALUE).
- so updates only on ops 010–110. It holds on HOLD, LOAD and CLR, and whenever en=0.
- Latency: one cycle. Result is visible on q/so after the edge that samples the op. No combinational path from d/si/op/en to q or so.
- Inputs may change anywhere between edges; only values at the rising edge matter. No setup-violation modelling in behavioural RTL.
- Boundaries:
  - Rotates with WIDTH=2 swap the two bits.
  - Eight consecutive ROL with WIDTH=8 return the original value.
  - ASR of all-ones stays all-ones; ASR of 1 gives 0 with so=1.
- Reset asserted mid-sequence (any op, en=1) wins that edge. Operation resumes from RESET_VALUE on the first edge with reset=0.
- No X propagation from unused ops: all 8 codes are defined.

Test Plan (WIDTH=8, RESET_VALUE=0, clock period 15 ns, stimulus changed away from edges):
1. Hold reset=1 for two edges with en=1, op=LOAD, d=8'hFF -> q=8'h00, so=0, zero=1 (reset beats load). Release reset; LOAD 8'hA5 -> q=8'hA5, zero=0 after one edge.
2. en=0; op=LOAD, d=8'h3C and op=SHL alternately for 4 edges -> q stays 8'hA5, so stays 0. Set en=1 -> op takes effect on the next edge only.
3. From 8'hA5:
   - SHL si=1 -> q=8'h4B, so=1.
   - SHR si=0 -> q=8'h25, so=1.
   - HOLD -> q=8'h25, so=1 unchanged.
4. From 8'h81:
   - ROL -> q=8'h03, so=1.
   - ROR -> q=8'h81, so=1.
   - Eight consecutive ROL from 8'h96 -> q=8'h96.
5. ASR cases:
   - LOAD 8'h80, ASR -> q=8'hC0, so=0.
   - LOAD 8'hFF, ASR -> q=8'hFF, so=1.
   - LOAD 8'h01, ASR -> q=8'h00, so=1, zero=1.
   - CLR from 8'h5A -> q=8'h00, so unchanged.
6. Reset mid-sequence during a run of SHL si=1 -> q=8'h00 on that edge. Second build with RESET_VALUE=8'h0F, WIDTH=2 variant: reset -> q=RESET_VALUE. WIDTH=2 ROL of 2'b01 -> 2'b10, so=0.

Source files
------------

// File: rtl/param_shift_reg_en.sv
// General-purpose WIDTH-bit register with clock enable, parallel load,
// logical/arithmetic shifts, rotates, clear, serial in/out and a zero flag.
module param_shift_reg_en #(
  parameter int unsigned           WIDTH       = 8,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] d,
  input  logic             si,
  output logic [WIDTH-1:0] q,
  output logic             so,
  output logic             zero
);

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_LOAD = 3'b001,
    OP_SHL  = 3'b010,
    OP_SHR  = 3'b011,
    OP_ROL  = 3'b100,
    OP_ROR  = 3'b101,
    OP_ASR  = 3'b110,
    OP_CLR  = 3'b111
  } op_t;

  logic [WIDTH-1:0] q_next;
  logic             so_next;

  always_comb begin
    q_next  = q;
    so_next = so;
    case (op_t'(op))
      OP_HOLD: q_next = q;
      OP_LOAD: q_next = d;
      OP_SHL: begin
        q_next  = {q[WIDTH-2:0], si};
        so_next = q[WIDTH-1];
      end
      OP_SHR: begin
        q_next  = {si, q[WIDTH-1:1]};
        so_next = q[0];
      end
      OP_ROL: begin
        q_next  = {q[WIDTH-2:0], q[WIDTH-1]};
        so_next = q[WIDTH-1];
      end
      OP_ROR: begin
        q_next  = {q[0], q[WIDTH-1:1]};
        so_next = q[0];
      end
      OP_ASR: begin
        q_next  = {q[WIDTH-1], q[WIDTH-1:1]};
        so_next = q[0];
      end
      OP_CLR: q_next = '0;
      default: q_next = q;
    endcase
  end

  // reset dominates en; en=0 freezes both q and so
  always_ff @(posedge clk) begin
    if (reset) begin
      q  <= RESET_VALUE;
      so <= 1'b0;
    end else if (en) begin
      q  <= q_next;
      so <= so_next;
    end
  end

  assign zero = (q == '0);

endmodule

// File: tb/tb_param_shift_reg_en.sv
// Directed bench for param_shift_reg_en: default 8-bit build, an 8-bit build
// with non-zero reset value, and a 2-bit build.
`timescale 1ns/1ps
module tb_param_shift_reg_en;

  localparam logic [2:0] HOLD = 3'b000, LOAD = 3'b001, SHL = 3'b010, SHR = 3'b011,
                         ROL  = 3'b100, ROR  = 3'b101, ASR = 3'b110, CLR = 3'b111;

  logic clk = 1'b0;
  logic reset;

  logic       en, si;
  logic [2:0] op;
  logic [7:0] d, q;
  logic       so, zero;

  logic       en_b, si_b;
  logic [2:0] op_b;
  logic [7:0] d_b, q_b;
  logic       so_b, zero_b;

  logic       en_c, si_c;
  logic [2:0] op_c;
  logic [1:0] d_c, q_c;
  logic       so_c, zero_c;

  int checks = 0;
  int failures = 0;

  always #7.5 clk = ~clk;

  param_shift_reg_en #(.WIDTH(8), .RESET_VALUE(8'h00)) u_dut (
    .clk(clk), .reset(reset), .en(en), .op(op), .d(d), .si(si),
    .q(q), .so(so), .zero(zero));

  param_shift_reg_en #(.WIDTH(8), .RESET_VALUE(8'h0F)) u_dut_rv (
    .clk(clk), .reset(reset), .en(en_b), .op(op_b), .d(d_b), .si(si_b),
    .q(q_b), .so(so_b), .zero(zero_b));

  param_shift_reg_en #(.WIDTH(2), .RESET_VALUE(2'b00)) u_dut_w2 (
    .clk(clk), .reset(reset), .en(en_c), .op(op_c), .d(d_c), .si(si_c),
    .q(q_c), .so(so_c), .zero(zero_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic op1(input logic [2:0] o, input logic [7:0] dv, input logic s);
    op = o; d = dv; si = s;
    tick();
  endtask

  initial begin
    en = 1'b1; op = LOAD; d = 8'hFF; si = 1'b0; reset = 1'b1;
    en_b = 1'b0; op_b = HOLD; d_b = '0; si_b = 1'b0;
    en_c = 1'b0; op_c = HOLD; d_c = '0; si_c = 1'b0;
    #3;

    // 1: reset beats load, then load
    tick(); tick();
    check("rst_q", q, 8'h00);
    check("rst_so", {7'b0, so}, 8'h00);
    check("rst_zero", {7'b0, zero}, 8'h01);
    reset = 1'b0;
    op1(LOAD, 8'hA5, 1'b0);
    check("load_q", q, 8'hA5);
    check("load_zero", {7'b0, zero}, 8'h00);

    // 2: enable low holds everything
    en = 1'b0;
    op1(LOAD, 8'h3C, 1'b1);
    op1(SHL, 8'h3C, 1'b1);
    op1(LOAD, 8'h3C, 1'b1);
    op1(SHL, 8'h3C, 1'b1);
    check("en0_q", q, 8'hA5);
    check("en0_so", {7'b0, so}, 8'h00);
    op = SHL; si = 1'b1; en = 1'b1;
    #2;
    check("en1_before_edge", q, 8'hA5);

    // 3: shifts and hold
    tick();
    check("shl_q", q, 8'h4B);
    check("shl_so", {7'b0, so}, 8'h01);
    op1(SHR, 8'h00, 1'b0);
    check("shr_q", q, 8'h25);
    check("shr_so", {7'b0, so}, 8'h01);
    op1(HOLD, 8'hFF, 1'b1);
    check("hold_q", q, 8'h25);
    check("hold_so", {7'b0, so}, 8'h01);

    // 4: rotates
    op1(LOAD, 8'h81, 1'b0);
    op1(ROL, 8'h00, 1'b0);
    check("rol_q", q, 8'h03);
    check("rol_so", {7'b0, so}, 8'h01);
    op1(ROR, 8'h00, 1'b0);
    check("ror_q", q, 8'h81);
    check("ror_so", {7'b0, so}, 8'h01);
    op1(LOAD, 8'h96, 1'b0);
    for (int i = 0; i < 8; i++) op1(ROL, 8'h00, 1'b0);
    check("rol8_q", q, 8'h96);

    // 5: arithmetic shift and clear
    op1(LOAD, 8'h80, 1'b1);
    op1(ASR, 8'h00, 1'b1);
    check("asr80_q", q, 8'hC0);
    check("asr80_so", {7'b0, so}, 8'h00);
    op1(LOAD, 8'hFF, 1'b0);
    op1(ASR, 8'h00, 1'b0);
    check("asrff_q", q, 8'hFF);
    check("asrff_so", {7'b0, so}, 8'h01);
    op1(LOAD, 8'h01, 1'b0);
    op1(ASR, 8'h00, 1'b0);
    check("asr01_q", q, 8'h00);
    check("asr01_so", {7'b0, so}, 8'h01);
    check("asr01_zero", {7'b0, zero}, 8'h01);
    op1(LOAD, 8'h5A, 1'b0);
    op1(CLR, 8'hFF, 1'b1);
    check("clr_q", q, 8'h00);
    check("clr_so", {7'b0, so}, 8'h01);

    // 6: reset mid-run of SHL
    op1(SHL, 8'h00, 1'b1);
    op1(SHL, 8'h00, 1'b1);
    check("shl_run_q", q, 8'h03);
    reset = 1'b1;
    op1(SHL, 8'h00, 1'b1);
    check("midrst_q", q, 8'h00);
    check("midrst_so", {7'b0, so}, 8'h00);
    reset = 1'b0;
    op1(SHL, 8'h00, 1'b1);
    check("resume_q", q, 8'h01);

    // non-zero reset value build
    check("rv_q", q_b, 8'h0F);
    check("rv_zero", {7'b0, zero_b}, 8'h00);
    en_b = 1'b1; op_b = SHL; si_b = 1'b0;
    tick();
    check("rv_shl_q", q_b, 8'h1E);
    check("rv_shl_so", {7'b0, so_b}, 8'h00);

    // 2-bit build
    check("w2_rst_q", {6'b0, q_c}, 8'h00);
    en_c = 1'b1; op_c = LOAD; d_c = 2'b01;
    tick();
    op_c = ROL;
    tick();
    check("w2_rol_q", {6'b0, q_c}, 8'h02);
    check("w2_rol_so", {7'b0, so_c}, 8'h00);
    op_c = ROR;
    tick();
    check("w2_ror_q", {6'b0, q_c}, 8'h01);
    check("w2_ror_so", {7'b0, so_c}, 8'h00);
    tick();
    check("w2_ror2_q", {6'b0, q_c}, 8'h02);
    check("w2_ror2_so", {7'b0, so_c}, 8'h01);
    op_c = SHR; si_c = 1'b1;
    tick();
    check("w2_shr_q", {6'b0, q_c}, 8'h03);
    check("w2_shr_so", {7'b0, so_c}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
